// File: rtl/display_timing_gen.sv
// display_timing_gen: parametrised raster timing with registered, mutually aligned position, sync, enable and strobes.
module display_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CORDW    = 10,
  parameter int FRAMEW   = 16
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic              ce,
  output logic [CORDW-1:0]  sx,
  output logic [CORDW-1:0]  sy,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              vblank,
  output logic              line_start,
  output logic              frame_start,
  output logic [FRAMEW-1:0] frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic HP = H_POL != 0;
  localparam logic VP = V_POL != 0;
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CORDW < 1 || CORDW > 30 || FRAMEW < 1 ||
      H_TOTAL - 1 >= (1 << CORDW) || V_TOTAL - 1 >= (1 << CORDW)) begin : g_bad_params
    $fatal(1, "display_timing_gen: invalid timing parameters");
  end
  function automatic logic hs_at(input logic [CORDW-1:0] x);
    return (int'(x) >= H_ACTIVE + H_FP && int'(x) < H_ACTIVE + H_FP + H_SYNC) ? HP : ~HP;
  endfunction
  function automatic logic vs_at(input logic [CORDW-1:0] y);
    return (int'(y) >= V_ACTIVE + V_FP && int'(y) < V_ACTIVE + V_FP + V_SYNC) ? VP : ~VP;
  endfunction
  logic [CORDW-1:0]  sx_q, sx_d, sy_q, sy_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, vblank_q, vblank_d;
  logic              line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [FRAMEW-1:0] frame_count_q, frame_count_d;
  // decodes use the next position so every output lands in the same cycle as sx/sy
  always_comb begin
    line_start_d  = ce && sx_q == H_LAST;
    frame_start_d = line_start_d && sy_q == V_LAST;
    sx_d          = ce ? (sx_q == H_LAST ? '0 : sx_q + CORDW'(1)) : sx_q;
    sy_d          = line_start_d ? (sy_q == V_LAST ? '0 : sy_q + CORDW'(1)) : sy_q;
    frame_count_d = frame_start_d ? frame_count_q + FRAMEW'(1) : frame_count_q;
    hsync_d       = hs_at(sx_d);
    vsync_d       = vs_at(sy_d);
    de_d          = int'(sx_d) < H_ACTIVE && int'(sy_d) < V_ACTIVE;
    vblank_d      = int'(sy_d) >= V_ACTIVE;
  end
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx_q          <= H_LAST;
      sy_q          <= V_LAST;
      hsync_q       <= hs_at(H_LAST);
      vsync_q       <= vs_at(V_LAST);
      de_q          <= 1'b0;
      vblank_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '1;
    end else begin
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      vblank_q      <= vblank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end
  assign sx          = sx_q;
  assign sy          = sy_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign vblank      = vblank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_display_timing_gen.sv
// tb_display_timing_gen: three modes checked against an advance-count reference model, a vector table and corner sequences.
module tb_display_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rst_v = '1, ce_v = '0;
  logic [9:0] sx0, sy0, sx1, sy1;
  logic [4:0] sx2, sy2;
  logic hs0, vs0, de0, vb0, ls0, fs0, hs1, vs1, de1, vb1, ls1, fs1, hs2, vs2, de2, vb2, ls2, fs2;
  logic [15:0] fc0;
  logic [3:0] fc1, fc2;
  display_timing_gen u0 (.clk_pix(clk), .rst(rst_v[0]), .ce(ce_v[0]), .sx(sx0), .sy(sy0), .hsync(hs0),
    .vsync(vs0), .de(de0), .vblank(vb0), .line_start(ls0), .frame_start(fs0), .frame_count(fc0));
  display_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .H_POL(1), .V_POL(1), .CORDW(10), .FRAMEW(4)) u1 (.clk_pix(clk), .rst(rst_v[1]), .ce(ce_v[1]),
    .sx(sx1), .sy(sy1), .hsync(hs1), .vsync(vs1), .de(de1), .vblank(vb1), .line_start(ls1),
    .frame_start(fs1), .frame_count(fc1));
  display_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2),
    .V_BP(3), .H_POL(0), .V_POL(0), .CORDW(5), .FRAMEW(4)) u2 (.clk_pix(clk), .rst(rst_v[2]), .ce(ce_v[2]),
    .sx(sx2), .sy(sy2), .hsync(hs2), .vsync(vs2), .de(de2), .vblank(vb2), .line_start(ls2),
    .frame_start(fs2), .frame_count(fc2));
  localparam int HA[3] = '{640, 4, 16};
  localparam int HF[3] = '{16, 1, 2};
  localparam int HSW[3] = '{96, 2, 4};
  localparam int HBP[3] = '{48, 1, 3};
  localparam int VA[3] = '{480, 3, 12};
  localparam int VF[3] = '{10, 1, 2};
  localparam int VSW[3] = '{2, 1, 2};
  localparam int VBP[3] = '{33, 1, 3};
  localparam int HP[3] = '{0, 1, 0};
  localparam int VP[3] = '{0, 1, 0};
  localparam int FW[3] = '{16, 4, 4};
  typedef struct { int sx, sy, hs, vs, de, vb, ls, fs, fc; } obs_t;
  typedef struct { logic rst, ce; int sx, sy, hs, vs, ls, fs, fc; } vec_t;
  int total = 0, bad = 0, cyc = 0;
  int n[3] = '{0, 0, 0};
  int adv[3] = '{0, 0, 0};
  vec_t tbl[14];
  // the model only counts advances since reset and derives everything from that count
  function automatic obs_t model(int i);
    obs_t e;
    int ht, vt, tot, p;
    ht = HA[i] + HF[i] + HSW[i] + HBP[i];
    vt = VA[i] + VF[i] + VSW[i] + VBP[i];
    tot = ht * vt;
    if (n[i] == 0) begin
      e.sx = ht - 1; e.sy = vt - 1; e.fc = (1 << FW[i]) - 1;
    end else begin
      p = (n[i] - 1) % tot;
      e.sx = p % ht; e.sy = p / ht; e.fc = ((n[i] - 1) / tot) % (1 << FW[i]);
    end
    e.hs = (e.sx >= HA[i] + HF[i] && e.sx < HA[i] + HF[i] + HSW[i]) ? HP[i] : 1 - HP[i];
    e.vs = (e.sy >= VA[i] + VF[i] && e.sy < VA[i] + VF[i] + VSW[i]) ? VP[i] : 1 - VP[i];
    e.de = (e.sx < HA[i] && e.sy < VA[i]) ? 1 : 0;
    e.vb = e.sy >= VA[i] ? 1 : 0;
    e.ls = (adv[i] != 0 && e.sx == 0) ? 1 : 0;
    e.fs = (e.ls != 0 && e.sy == 0) ? 1 : 0;
    return e;
  endfunction
  function automatic obs_t actual(int i);
    obs_t a;
    if (i == 0) a = '{int'(sx0), int'(sy0), int'(hs0), int'(vs0), int'(de0), int'(vb0), int'(ls0), int'(fs0), int'(fc0)};
    else if (i == 1) a = '{int'(sx1), int'(sy1), int'(hs1), int'(vs1), int'(de1), int'(vb1), int'(ls1), int'(fs1), int'(fc1)};
    else a = '{int'(sx2), int'(sy2), int'(hs2), int'(vs2), int'(de2), int'(vb2), int'(ls2), int'(fs2), int'(fc2)};
    return a;
  endfunction
  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic check_models();
    for (int i = 0; i < 3; i++) begin
      obs_t e, a;
      e = model(i);
      a = actual(i);
      cmp($sformatf("u%0d.sx", i), a.sx, e.sx);
      cmp($sformatf("u%0d.sy", i), a.sy, e.sy);
      cmp($sformatf("u%0d.hsync", i), a.hs, e.hs);
      cmp($sformatf("u%0d.vsync", i), a.vs, e.vs);
      cmp($sformatf("u%0d.de", i), a.de, e.de);
      cmp($sformatf("u%0d.vblank", i), a.vb, e.vb);
      cmp($sformatf("u%0d.line_start", i), a.ls, e.ls);
      cmp($sformatf("u%0d.frame_start", i), a.fs, e.fs);
      cmp($sformatf("u%0d.frame_count", i), a.fc, e.fc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i]) begin n[i] = 0; adv[i] = 0; end
      else if (ce_v[i]) begin n[i]++; adv[i] = 1; end
      else adv[i] = 0;
    end
    cyc++;
    #1;
    check_models();
  endtask
  initial begin
    int lows, first_blank, last, pulses, wrapped;
    tbl[0]  = '{1'b1, 1'b0, 7, 5, 0, 0, 0, 0, 15};
    tbl[1]  = '{1'b0, 1'b1, 0, 0, 0, 0, 1, 1, 0};
    tbl[2]  = '{1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 2, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 3, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 4, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1'b0, 1'b1, 5, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 5, 0, 1, 0, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 6, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 7, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b1, 0, 1, 0, 0, 1, 0, 0};
    tbl[12] = '{1'b1, 1'b1, 7, 5, 0, 0, 0, 0, 15};
    tbl[13] = '{1'b0, 1'b1, 0, 0, 0, 0, 1, 1, 0};
    step(); step();
    cmp("rst_sx", int'(sx0), 799); cmp("rst_sy", int'(sy0), 524); cmp("rst_de", int'(de0), 0);
    cmp("rst_vblank", int'(vb0), 1); cmp("rst_hsync", int'(hs0), 1); cmp("rst_vsync", int'(vs0), 1);
    cmp("rst_fc", int'(fc0), 65535);
    for (int k = 0; k < 14; k++) begin
      rst_v[1] = tbl[k].rst; ce_v[1] = tbl[k].ce;
      step();
      cmp($sformatf("tbl%0d.sx", k), int'(sx1), tbl[k].sx);
      cmp($sformatf("tbl%0d.sy", k), int'(sy1), tbl[k].sy);
      cmp($sformatf("tbl%0d.hsync", k), int'(hs1), tbl[k].hs);
      cmp($sformatf("tbl%0d.vsync", k), int'(vs1), tbl[k].vs);
      cmp($sformatf("tbl%0d.line_start", k), int'(ls1), tbl[k].ls);
      cmp($sformatf("tbl%0d.frame_start", k), int'(fs1), tbl[k].fs);
      cmp($sformatf("tbl%0d.frame_count", k), int'(fc1), tbl[k].fc);
    end
    rst_v[0] = 1'b0; ce_v[0] = 1'b1;
    step();
    cmp("first_sx", int'(sx0), 0); cmp("first_sy", int'(sy0), 0); cmp("first_de", int'(de0), 1);
    cmp("first_fs", int'(fs0), 1); cmp("first_ls", int'(ls0), 1); cmp("first_fc", int'(fc0), 0);
    cmp("first_hsync", int'(hs0), 1); cmp("first_vsync", int'(vs0), 1);
    lows = 0; first_blank = -1;
    for (int k = 0; k < 799; k++) begin
      step();
      if (!hs0) lows++;
      if (!de0 && first_blank < 0) first_blank = int'(sx0);
    end
    cmp("hsync_low_count", lows, 96); cmp("de_first_low_sx", first_blank, 640);
    cmp("line_end_sx", int'(sx0), 799);
    step();
    cmp("wrap_sx", int'(sx0), 0); cmp("wrap_sy", int'(sy0), 1);
    cmp("wrap_ls", int'(ls0), 1); cmp("wrap_fs", int'(fs0), 0);
    last = -1; pulses = 0;
    for (int k = 0; k < 5200; k++) begin
      ce_v[0] = (k % 3 == 0);
      step();
      if (ls0) begin
        if (last >= 0) cmp("line_period_div3", cyc - last, 2400);
        last = cyc; pulses++;
      end
    end
    cmp("div3_pulses_seen", pulses >= 2 ? 1 : 0, 1);
    ce_v[0] = 1'b1;
    for (int k = 0; k < 2000 && sx0 != 10'd300; k++) step();
    cmp("reached_sx300", int'(sx0), 300);
    rst_v[0] = 1'b1;
    step();
    cmp("midrst_sx", int'(sx0), 799); cmp("midrst_sy", int'(sy0), 524);
    cmp("midrst_fc", int'(fc0), 65535); cmp("midrst_ls", int'(ls0), 0);
    rst_v[0] = 1'b0;
    step();
    cmp("restart_sx", int'(sx0), 0); cmp("restart_sy", int'(sy0), 0);
    cmp("restart_fs", int'(fs0), 1); cmp("restart_fc", int'(fc0), 0);
    rst_v[2] = 1'b1; step();
    rst_v[2] = 1'b0; ce_v[2] = 1'b1;
    last = -1; wrapped = 0;
    for (int k = 0; k < 16 * 475 + 5; k++) begin
      step();
      if (fs2) begin
        if (last >= 0) cmp("frame_period_u2", cyc - last, 475);
        if (last >= 0 && fc2 == 4'd0) wrapped = 1;
        last = cyc;
      end
    end
    cmp("fc_wrap_seen_u2", wrapped, 1);
    for (int k = 0; k < 20000; k++) begin
      for (int i = 0; i < 3; i++) begin
        ce_v[i] = 1'($urandom_range(0, 1));
        rst_v[i] = (i != 0) && ($urandom_range(0, 2999) == 0);
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/display_timing_gen.md
# display_timing_gen

Parametrised raster timing generator, successor to the fixed 640x480 timing block. Produces pixel coordinates, sync, data-enable, blanking and frame/line strobes for any mode described by porch/sync/active parameters. Sync polarity is configurable and a clock-enable allows a divided pixel rate from a faster clock. All outputs are registered and mutually aligned. Sits between the clock/reset logic and the pixel pipeline (PPU/renderer, then the TMDS/VGA output stage).

## Interface
- H_ACTIVE, 640: active pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: horizontal sync width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: active lines per frame
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width (lines)
- V_BP, 33: vertical back porch (lines)
- H_POL, 0: hsync active level (0 = active-low)
- V_POL, 0: vsync active level (0 = active-low)
- CORDW, 10: coordinate width
- FRAMEW, 16: frame counter width
- clk_pix  in  1  pixel/system clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel advance enable; position advances only on cycles with ce=1
- sx  out  CORDW  horizontal position, 0..H_TOTAL-1
- sy  out  CORDW  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per H_POL
- vsync  out  1  vertical sync, level per V_POL
- de  out  1  high when sx<H_ACTIVE and sy<V_ACTIVE
- vblank  out  1  high when sy>=V_ACTIVE
- line_start  out  1  one-clk pulse on arriving at sx=0
- frame_start  out  1  one-clk pulse on arriving at (0,0)
- frame_count  out  FRAMEW  index of the current frame, wraps modulo 2^FRAMEW

## Operation
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Elaboration check: H_TOTAL-1 and V_TOTAL-1 must fit in CORDW, and every parameter must be >=1. Violation is a fatal elaboration error.
- Horizontal sync is active for H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC. Vertical sync uses the same form with the V parameters on sy.
- hsync is decoded from sx only. It is asserted on every line, including vblank lines.
- Advance on clk edge with ce=1 and rst=0:
  - sx == H_TOTAL-1: sx<=0. sy<=0 if sy == V_TOTAL-1, else sy+1.
  - Otherwise: sx<=sx+1.
- When ce=0, sx, sy, hsync, vsync, de, vblank and frame_count all hold.
- Strobes:
  - line_start is 1 for exactly one clk cycle following an advance that lands on sx=0. It is 0 on every other cycle, including held ce=0 cycles.
  - frame_start behaves the same for landing on (0,0). It always coincides with a line_start.
- frame_count increments on the same advance that raises frame_start.
- Reset state: sx=H_TOTAL-1, sy=V_TOTAL-1, de=0, vblank=1, line_start=0, frame_start=0, frame_count=all ones. hsync and vsync take the decoded levels for that position; with defaults both are inactive (1).
- The first ce after reset therefore lands on (0,0) with frame_start=1 and frame_count=0.
- rst has priority over ce at any point mid-frame.
- No free-running state exists outside the registered position.

## Timing
- Every output is a flop. hsync, vsync, de, vblank and the strobes are computed from the next position, so they align with sx/sy in the same cycle with zero relative skew.
- Latency: position and all decodes change on the clk edge of a ce=1 cycle. No combinational path exists from ce or rst to any output.
- Period at constant ce=1: H_TOTAL clk per line and H_TOTAL*V_TOTAL clk per frame (defaults: 800 and 420000).
- With ce asserted every Nth clk, all periods scale by N. Strobe width stays 1 clk.
- Counter widths are CORDW with no truncation. frame_count wraps from 2^FRAMEW-1 to 0 silently.

## Test plan
- Reset released with ce=1, defaults -> first cycle shows sx=0, sy=0, de=1, frame_start=1, line_start=1, frame_count=0, hsync=1, vsync=1.
- Line sweep -> hsync=0 exactly for sx 656..751. de=0 from sx=640. At sx=799 the next cycle shows sx=0, sy=1, line_start=1, frame_start=0.
- Full frame with ce=1 -> vsync=0 for sy 490..491, vblank for sy 480..524, and the next frame_start exactly 420000 clk later with frame_count=1. Repeat to check the wrap at FRAMEW=4 (16 -> 0).
- ce high every 3rd clk -> line period 2400 clk. Strobes stay 1 clk wide. Outputs are stable across the ce=0 cycles.
- H_POL=1, V_POL=1 with small mode (H 4/1/2/1, V 3/1/1/1) -> H_TOTAL=8, V_TOTAL=6, hsync=1 only at sx 5..6, vsync=1 only at sy 4. Compare exhaustively against a reference model over 3 frames.
- rst asserted mid-frame at (300,200) with ce=1 -> next cycle shows the reset state. After release, the first ce restarts at (0,0) with frame_start=1 and frame_count=0.
